// File: rtl/vec_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// vec_hazard_unit_if
// Bundle between the vector CPU pipeline and its hazard unit.
//   Pipeline -> hazard unit : register indices in ID/EX/MEM/WB, write enables,
//                             load flag and vector-memory flag of the EX op.
//   Hazard unit -> pipeline : forwarding selects, stall/flush controls,
//                             current vector lane, last-beat flag and the
//                             saturating stall counter.
// The pipeline side uses the master modport, the hazard unit the slave one.
// ---------------------------------------------------------------------------
interface vec_hazard_unit_if #(
    parameter int LW = 3,
    parameter int CW = 16
);
    logic [3:0]    RA1D;
    logic [3:0]    RA2D;
    logic [3:0]    RA1E;
    logic [3:0]    RA2E;
    logic [3:0]    WA3E;
    logic [3:0]    WA3M;
    logic [3:0]    WA3W;
    logic          RegWriteE;
    logic          RegWriteM;
    logic          RegWriteW;
    logic          MemtoRegE;
    logic          VecMemE;
    logic [1:0]    ForwardAE;
    logic [1:0]    ForwardBE;
    logic          StallF;
    logic          StallD;
    logic          StallE;
    logic          FlushE;
    logic [LW-1:0] LaneIdx;
    logic          VecLastBeat;
    logic [CW-1:0] StallCount;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, VecMemE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushE,
        input  LaneIdx, VecLastBeat, StallCount
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, VecMemE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushE,
        output LaneIdx, VecLastBeat, StallCount
    );
endinterface

// File: rtl/vec_hazard_unit.sv
// ---------------------------------------------------------------------------
// vec_hazard_unit
// Pipeline control for the vector CPU's ID/EX register: operand forwarding
// selects, load-use stall/bubble, and lane-serial sequencing of vector memory
// accesses (one lane per cycle over R lanes), plus a saturating count of
// stalled cycles.
// Ports:
//   clk    - pipeline clock; state changes on the falling edge like the
//            pipeline registers
//   reset  - asynchronous, active-high; forces IDLE and zeroes all outputs
//   hz     - vec_hazard_unit_if.slave carrying pipeline indices/flags in and
//            ForwardAE/BE, StallF/D/E, FlushE, LaneIdx, VecLastBeat,
//            StallCount out
// ---------------------------------------------------------------------------
module vec_hazard_unit #(
    parameter int R  = 6,
    parameter int LW = (R > 1) ? $clog2(R) : 1,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             reset,
    vec_hazard_unit_if.slave hz
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [LW-1:0] LastLane = LW'(R - 1);

    state_t        state_q, state_d;
    logic [LW-1:0] laneCnt_q, laneCnt_d;
    logic [CW-1:0] stallCount_q, stallCount_d;

    logic [1:0]    fwdA, fwdB;
    logic          loadUse;
    logic          stallF, stallD, stallE, flushE;
    logic          lastBeat;
    logic [LW-1:0] laneIdx;

    // Forwarding selects: the MEM result is younger than the WB result, so it
    // wins when both would supply the same source register.
    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (!reset) begin
            if (hz.RegWriteM && (hz.WA3M == hz.RA1E))
                fwdA = 2'b10;
            else if (hz.RegWriteW && (hz.WA3W == hz.RA1E))
                fwdA = 2'b01;

            if (hz.RegWriteM && (hz.WA3M == hz.RA2E))
                fwdB = 2'b10;
            else if (hz.RegWriteW && (hz.WA3W == hz.RA2E))
                fwdB = 2'b01;
        end
    end

    // A load in EX whose destination is read by the instruction in ID.
    assign loadUse = hz.MemtoRegE && hz.RegWriteE &&
                     ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));

    // Lane sequencer and stall/flush generation. Vector beats own the stall
    // controls, so load-use only acts in IDLE with no vector op in EX. On the
    // last beat all stalls drop so the pipeline advances at that edge.
    always_comb begin
        state_d   = state_q;
        laneCnt_d = laneCnt_q;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        flushE    = 1'b0;
        lastBeat  = 1'b0;
        laneIdx   = '0;

        case (state_q)
            IDLE: begin
                if (hz.VecMemE) begin
                    if (R > 1) begin
                        stallF    = 1'b1;
                        stallD    = 1'b1;
                        stallE    = 1'b1;
                        state_d   = BUSY;
                        laneCnt_d = LW'(1);
                    end else begin
                        lastBeat  = 1'b1;
                    end
                end else begin
                    stallF = loadUse;
                    stallD = loadUse;
                    flushE = loadUse;
                end
            end
            BUSY: begin
                laneIdx = laneCnt_q;
                if (laneCnt_q == LastLane) begin
                    lastBeat  = 1'b1;
                    state_d   = IDLE;
                    laneCnt_d = '0;
                end else begin
                    stallF    = 1'b1;
                    stallD    = 1'b1;
                    stallE    = 1'b1;
                    laneCnt_d = laneCnt_q + LW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                laneCnt_d = '0;
            end
        endcase

        if (reset) begin
            stallF   = 1'b0;
            stallD   = 1'b0;
            stallE   = 1'b0;
            flushE   = 1'b0;
            lastBeat = 1'b0;
            laneIdx  = '0;
        end
    end

    // Stall counter sticks at all-ones instead of wrapping.
    always_comb begin
        stallCount_d = stallCount_q;
        if (stallD && (stallCount_q != '1))
            stallCount_d = stallCount_q + CW'(1);
    end

    // Falling-edge state registers with asynchronous reset.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            laneCnt_q    <= '0;
            stallCount_q <= '0;
        end else begin
            state_q      <= state_d;
            laneCnt_q    <= laneCnt_d;
            stallCount_q <= stallCount_d;
        end
    end

    assign hz.ForwardAE   = fwdA;
    assign hz.ForwardBE   = fwdB;
    assign hz.StallF      = stallF;
    assign hz.StallD      = stallD;
    assign hz.StallE      = stallE;
    assign hz.FlushE      = flushE;
    assign hz.LaneIdx     = laneIdx;
    assign hz.VecLastBeat = lastBeat;
    assign hz.StallCount  = stallCount_q;

endmodule

// File: tb/tb_vec_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_vec_hazard_unit
// Bench for vec_hazard_unit with R=6. A second instance with CW=4 sees the
// same stimulus so the stall counter can be driven into saturation quickly.
// Inputs change on the rising edge and outputs are sampled 1 time unit later,
// well away from the falling edge that updates the DUT state.
// ---------------------------------------------------------------------------
module tb_vec_hazard_unit;

    typedef struct {
        string       tag;
        logic [27:0] v;
    } exp_t;

    logic        clk;
    logic        reset;
    int          testsRun;
    int          failCount;
    logic [15:0] expCount;
    logic [3:0]  expSat;
    exp_t        sb[$];
    exp_t        ent;
    logic [27:0] obs;

    vec_hazard_unit_if #(.LW(3), .CW(16)) hzIf();
    vec_hazard_unit_if #(.LW(3), .CW(4))  satIf();

    vec_hazard_unit #(.R(6), .LW(3), .CW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hzIf)
    );

    vec_hazard_unit #(.R(6), .LW(3), .CW(4)) dutSat (
        .clk   (clk),
        .reset (reset),
        .hz    (satIf)
    );

    // The saturation instance mirrors the main instance's inputs.
    assign satIf.RA1D      = hzIf.RA1D;
    assign satIf.RA2D      = hzIf.RA2D;
    assign satIf.RA1E      = hzIf.RA1E;
    assign satIf.RA2E      = hzIf.RA2E;
    assign satIf.WA3E      = hzIf.WA3E;
    assign satIf.WA3M      = hzIf.WA3M;
    assign satIf.WA3W      = hzIf.WA3W;
    assign satIf.RegWriteE = hzIf.RegWriteE;
    assign satIf.RegWriteM = hzIf.RegWriteM;
    assign satIf.RegWriteW = hzIf.RegWriteW;
    assign satIf.MemtoRegE = hzIf.MemtoRegE;
    assign satIf.VecMemE   = hzIf.VecMemE;

    assign obs = {hzIf.ForwardAE, hzIf.ForwardBE, hzIf.StallF, hzIf.StallD,
                  hzIf.StallE, hzIf.FlushE, hzIf.LaneIdx, hzIf.VecLastBeat,
                  hzIf.StallCount};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] expVec(input logic [1:0] fa, input logic [1:0] fb,
                                           input logic sf, input logic sd,
                                           input logic se, input logic fe,
                                           input logic [2:0] lane, input logic last,
                                           input logic [15:0] cnt);
        return {fa, fb, sf, sd, se, fe, lane, last, cnt};
    endfunction

    task automatic clearInputs();
        hzIf.RA1D      = 4'd0;
        hzIf.RA2D      = 4'd0;
        hzIf.RA1E      = 4'd0;
        hzIf.RA2E      = 4'd0;
        hzIf.WA3E      = 4'd0;
        hzIf.WA3M      = 4'd0;
        hzIf.WA3W      = 4'd0;
        hzIf.RegWriteE = 1'b0;
        hzIf.RegWriteM = 1'b0;
        hzIf.RegWriteW = 1'b0;
        hzIf.MemtoRegE = 1'b0;
        hzIf.VecMemE   = 1'b0;
    endtask

    // Drives a generic set of operand/flag values for one cycle.
    task automatic applyStimulus(input logic [3:0] ra1d, input logic [3:0] ra2d,
                                 input logic [3:0] wa3e, input logic m2r,
                                 input logic rwe, input logic vec);
        hzIf.RA1D      = ra1d;
        hzIf.RA2D      = ra2d;
        hzIf.WA3E      = wa3e;
        hzIf.MemtoRegE = m2r;
        hzIf.RegWriteE = rwe;
        hzIf.VecMemE   = vec;
    endtask

    // Advances the expected stall counters past a falling edge.
    task automatic bumpCounts(input logic sd);
        if (sd) begin
            expCount = expCount + 16'd1;
            if (expSat != 4'hF)
                expSat = expSat + 4'd1;
        end
    endtask

    // Reset with inputs that would otherwise forward, stall and flush.
    task automatic test_reset();
        @(posedge clk);
        reset = 1'b1;
        hzIf.RegWriteM = 1'b1;
        hzIf.WA3M      = 4'd3;
        hzIf.RA1E      = 4'd3;
        hzIf.RA2E      = 4'd3;
        applyStimulus(4'd2, 4'd0, 4'd2, 1'b1, 1'b1, 1'b1);
        expCount = 16'd0;
        expSat   = 4'd0;
        sb.push_back('{"reset", expVec(2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 0, 16'd0)});
        #1;
        ent = sb.pop_front();
        testsRun++;
        if (obs !== ent.v) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", ent.tag, obs, ent.v);
        end
        testsRun++;
        if (satIf.StallCount !== expSat) begin
            failCount++;
            $display("[TB] FAIL reset_sat: observed %0d expected %0d", satIf.StallCount, expSat);
        end
        @(posedge clk);
        reset = 1'b0;
        clearInputs();
    endtask

    // Forwarding priority and write-enable gating.
    task automatic test_forwarding();
        logic [1:0] efa, efb;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            clearInputs();
            hzIf.RA1E = 4'd3;
            hzIf.RA2E = 4'd5;
            case (i)
                0: begin
                    hzIf.RegWriteM = 1'b1; hzIf.WA3M = 4'd3;
                    hzIf.RegWriteW = 1'b1; hzIf.WA3W = 4'd3;
                    efa = 2'b10; efb = 2'b00;
                end
                1: begin
                    hzIf.RegWriteM = 1'b0; hzIf.WA3M = 4'd3;
                    hzIf.RegWriteW = 1'b1; hzIf.WA3W = 4'd3;
                    efa = 2'b01; efb = 2'b00;
                end
                2: begin
                    hzIf.RegWriteM = 1'b1; hzIf.WA3M = 4'd5;
                    hzIf.RegWriteW = 1'b1; hzIf.WA3W = 4'd3;
                    efa = 2'b01; efb = 2'b10;
                end
                3: begin
                    hzIf.RegWriteM = 1'b1; hzIf.WA3M = 4'd9;
                    hzIf.RegWriteW = 1'b0; hzIf.WA3W = 4'd3;
                    efa = 2'b00; efb = 2'b00;
                end
                default: begin
                    hzIf.RegWriteM = 1'b0; hzIf.WA3M = 4'd3;
                    hzIf.RegWriteW = 1'b1; hzIf.WA3W = 4'd5;
                    efa = 2'b00; efb = 2'b01;
                end
            endcase
            sb.push_back('{$sformatf("fwd%0d", i),
                           expVec(efa, efb, 0, 0, 0, 0, 3'd0, 0, expCount)});
            #1;
            ent = sb.pop_front();
            testsRun++;
            if (obs !== ent.v) begin
                failCount++;
                $display("[TB] FAIL %s: observed %h expected %h", ent.tag, obs, ent.v);
            end
        end
    endtask

    // Load-use detection on either ID source, gated by RegWriteE.
    task automatic test_load_use();
        logic lu;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            clearInputs();
            case (i)
                0: begin applyStimulus(4'd1, 4'd4, 4'd4, 1'b1, 1'b1, 1'b0); lu = 1'b1; end
                1: begin applyStimulus(4'd1, 4'd4, 4'd4, 1'b0, 1'b1, 1'b0); lu = 1'b0; end
                2: begin applyStimulus(4'd1, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0); lu = 1'b0; end
                3: begin applyStimulus(4'd7, 4'd0, 4'd7, 1'b1, 1'b1, 1'b0); lu = 1'b1; end
                default: begin applyStimulus(4'd1, 4'd2, 4'd7, 1'b1, 1'b1, 1'b0); lu = 1'b0; end
            endcase
            sb.push_back('{$sformatf("lu%0d", i),
                           expVec(2'b00, 2'b00, lu, lu, 0, lu, 3'd0, 0, expCount)});
            #1;
            ent = sb.pop_front();
            testsRun++;
            if (obs !== ent.v) begin
                failCount++;
                $display("[TB] FAIL %s: observed %h expected %h", ent.tag, obs, ent.v);
            end
            bumpCounts(lu);
        end
    endtask

    // Six-beat vector access with MEM forwarding live throughout.
    task automatic test_vector();
        logic sd, last;
        logic [2:0] lane;
        clearInputs();
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            hzIf.RegWriteM = 1'b1;
            hzIf.WA3M      = 4'd3;
            hzIf.RA1E      = 4'd3;
            hzIf.VecMemE   = (k < 6);
            sd   = (k < 5);
            last = (k == 5);
            lane = (k < 6) ? 3'(k) : 3'd0;
            sb.push_back('{$sformatf("vec%0d", k),
                           expVec(2'b10, 2'b00, sd, sd, sd, 0, lane, last, expCount)});
            #1;
            ent = sb.pop_front();
            testsRun++;
            if (obs !== ent.v) begin
                failCount++;
                $display("[TB] FAIL %s: observed %h expected %h", ent.tag, obs, ent.v);
            end
            bumpCounts(sd);
        end
    endtask

    // Vector access overlapping a load-use match: no flush on any beat, then
    // load-use acts on the cycle after the last beat.
    task automatic test_vec_lu();
        logic sd, se, fe, last;
        logic [2:0] lane;
        clearInputs();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            hzIf.RegWriteW = 1'b1;
            hzIf.WA3W      = 4'd6;
            hzIf.RA2E      = 4'd6;
            applyStimulus(4'd2, 4'd0, 4'd2, (k < 7), 1'b1, (k < 6));
            if (k < 6) begin
                sd = (k < 5); se = sd; fe = 1'b0;
                last = (k == 5); lane = 3'(k);
            end else begin
                sd = (k == 6); se = 1'b0; fe = sd;
                last = 1'b0; lane = 3'd0;
            end
            sb.push_back('{$sformatf("veclu%0d", k),
                           expVec(2'b00, 2'b01, sd, sd, se, fe, lane, last, expCount)});
            #1;
            ent = sb.pop_front();
            testsRun++;
            if (obs !== ent.v) begin
                failCount++;
                $display("[TB] FAIL %s: observed %h expected %h", ent.tag, obs, ent.v);
            end
            bumpCounts(sd);
        end
    endtask

    // Reset landing on beat 3, then a fresh access from lane 0.
    task automatic test_reset_mid();
        int   beat;
        logic sd, last, inRst;
        clearInputs();
        for (int s = 0; s < 11; s++) begin
            @(posedge clk);
            inRst = (s == 3);
            reset = inRst;
            hzIf.VecMemE = (s < 10);
            beat = (s < 3) ? s : s - 4;
            if (inRst) begin
                expCount = 16'd0;
                expSat   = 4'd0;
            end
            sd   = !inRst && (s < 10) && (beat < 5);
            last = !inRst && (s < 10) && (beat == 5);
            sb.push_back('{$sformatf("rstmid%0d", s),
                           expVec(2'b00, 2'b00, sd, sd, sd, 0,
                                  (inRst || s == 10) ? 3'd0 : 3'(beat), last, expCount)});
            #1;
            ent = sb.pop_front();
            testsRun++;
            if (obs !== ent.v) begin
                failCount++;
                $display("[TB] FAIL %s: observed %h expected %h", ent.tag, obs, ent.v);
            end
            bumpCounts(sd);
        end
    endtask

    // Three back-to-back accesses plus a load-use stall push the 4-bit
    // counter to its ceiling while the 16-bit one keeps counting.
    task automatic test_saturation();
        logic sd, se, fe, last;
        logic [2:0] lane;
        clearInputs();
        for (int s = 0; s < 21; s++) begin
            @(posedge clk);
            reset = (s == 0);
            if (s == 0) begin
                expCount = 16'd0;
                expSat   = 4'd0;
            end
            applyStimulus(4'd2, 4'd0, 4'd2, (s == 19), 1'b1, (s >= 1 && s <= 18));
            sd = 1'b0; se = 1'b0; fe = 1'b0; last = 1'b0; lane = 3'd0;
            if (s >= 1 && s <= 18) begin
                lane = 3'((s - 1) % 6);
                sd   = (lane != 3'd5);
                se   = sd;
                last = (lane == 3'd5);
            end else if (s == 19) begin
                sd = 1'b1;
                fe = 1'b1;
            end
            sb.push_back('{$sformatf("sat%0d", s),
                           expVec(2'b00, 2'b00, sd, sd, se, fe, lane, last, expCount)});
            #1;
            ent = sb.pop_front();
            testsRun++;
            if (obs !== ent.v) begin
                failCount++;
                $display("[TB] FAIL %s: observed %h expected %h", ent.tag, obs, ent.v);
            end
            testsRun++;
            if (satIf.StallCount !== expSat) begin
                failCount++;
                $display("[TB] FAIL satcnt%0d: observed %0d expected %0d", s, satIf.StallCount, expSat);
            end
            bumpCounts(sd);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun  = 0;
        failCount = 0;
        expCount  = 16'd0;
        expSat    = 4'd0;
        reset     = 1'b1;
        clearInputs();

        test_reset();
        test_forwarding();
        test_load_use();
        test_vector();
        test_vec_lu();
        test_reset_mid();
        test_saturation();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/vec_hazard_unit.md
Name: vec_hazard_unit

Overview:
- Pipeline-control counterpart of the vector CPU's ID/EX stage register.
- The ID/EX register captures decode-side state; this block consumes the register's EX-side outputs plus MEM/WB write-backs to produce the signals that drive it: forwarding selects, stall and flush controls.
- It also sequences multi-beat vector memory accesses, one lane per cycle over R lanes, through a lane counter FSM.

Parameters:
- R, 6, number of vector lanes; the lane counter counts 0..R-1.
- LW, $clog2(R) (minimum 1), width of LaneIdx.
- CW, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on negedge clk, matching the pipeline registers.
- reset  in  1  reset, asynchronous, active-high.
- RA1D  in  4  source register A index in ID.
- RA2D  in  4  source register B index in ID.
- RA1E  in  4  source register A index in EX.
- RA2E  in  4  source register B index in EX.
- WA3E  in  4  destination index in EX.
- WA3M  in  4  destination index in MEM.
- WA3W  in  4  destination index in WB.
- RegWriteE  in  1  EX instruction writes a register.
- RegWriteM  in  1  MEM instruction writes a register.
- RegWriteW  in  1  WB instruction writes a register.
- MemtoRegE  in  1  EX instruction is a load.
- VecMemE  in  1  EX instruction is a lane-serial vector memory access.
- ForwardAE  out  2  operand A source: 00 register file, 10 MEM result, 01 WB result.
- ForwardBE  out  2  operand B source, same encoding.
- StallF  out  1  hold PC/IF.
- StallD  out  1  hold IF/ID.
- StallE  out  1  hold ID/EX.
- FlushE  out  1  clear ID/EX (insert bubble).
- LaneIdx  out  LW  current vector memory lane.
- VecLastBeat  out  1  current beat is lane R-1.
- StallCount  out  CW  saturating count of stalled cycles.

Behaviour:
Forwarding (combinational):
- ForwardAE=10 if RegWriteM && WA3M==RA1E; else 01 if RegWriteW && WA3W==RA1E; else 00. MEM has priority over WB.
- ForwardBE uses the same rule with RA2E.

Load-use hazard:
- LU = MemtoRegE && RegWriteE && (WA3E==RA1D || WA3E==RA2D).
- In IDLE with VecMemE=0: StallF=StallD=FlushE=LU and StallE=0. This lasts exactly one cycle, because the bubble clears MemtoRegE.

Vector memory FSM:
- States: IDLE and BUSY. Internal lane counter cnt, width LW.
- IDLE, VecMemE=1, R>1: beat 0. LaneIdx=0; StallF=StallD=StallE=1; FlushE=0. Next negedge: BUSY, cnt=1.
- IDLE, VecMemE=1, R==1: single beat. VecLastBeat=1, no stall, stays IDLE.
- BUSY, cnt<R-1: LaneIdx=cnt; StallF=StallD=StallE=1; VecMemE ignored. Next negedge: cnt+1.
- BUSY, cnt==R-1: VecLastBeat=1; all stalls 0, so the pipeline advances at this edge. Next negedge: IDLE, cnt=0.
- An R-lane access occupies EX for R cycles and stalls for R-1 cycles.
- LaneIdx=0 and VecLastBeat=0 in IDLE when VecMemE=0.

Priority:
- Vector sequencing overrides load-use. LU is ignored (FlushE=0) while StallE=1 or during any vector beat.
- LU is re-evaluated normally on the cycle after the last beat.
- Forwarding remains active in all states.

StallCount:
- Increments on each negedge where StallD=1.
- Saturates at 2^CW-1 and does not wrap.

Reset:
- Asynchronous, applies at any time including mid-BUSY: state=IDLE, cnt=0, StallCount=0.
- During reset: ForwardAE=ForwardBE=00, StallF=StallD=StallE=FlushE=0, LaneIdx=0, VecLastBeat=0.
- Reset overrides all inputs.

Test Plan:
1. RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3, RA2E=5 -> ForwardAE=10 (MEM wins), ForwardBE=00. Then set RegWriteM=0 -> ForwardAE=01.
2. Load-use: MemtoRegE=1, RegWriteE=1, WA3E=4, RA2D=4, VecMemE=0 -> StallF=StallD=FlushE=1, StallE=0 for one cycle. Next cycle MemtoRegE=0 -> all 0; StallCount=1.
3. Vector access, R=6: VecMemE=1 held -> LaneIdx 0,1,2,3,4,5 on consecutive cycles; StallE=1 on beats 0-4; VecLastBeat=1 only on beat 5; IDLE afterwards; StallCount=5.
4. Simultaneous: VecMemE=1 with a load-use match (WA3E=RA1D=2, MemtoRegE=1) -> FlushE=0 for all 6 beats. The cycle after the last beat evaluates LU against the new operands.
5. Reset at beat 3 of a vector access -> LaneIdx=0, all stalls 0, StallCount=0 immediately. After release with VecMemE=1, the sequence restarts at LaneIdx=0.
6. CW=4, VecMemE asserted for three consecutive vector accesses (15 stall cycles) followed by a further load-use stall -> StallCount holds at 15.
